// File: rtl/disp_pkg.sv
// Shared types and segment tables for the multiplexed 7-segment scanner.
package disp_pkg;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Index n holds the a..g pattern for hex digit n (bit 0 = a).
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Position of the most significant nonzero nibble among the low n; 0 if all zero.
    function automatic int top_digit(input logic [31:0] v, input int n);
        int top;
        top = 0;
        for (int i = 0; i < 8; i++)
            if (i < n && v[4*i +: 4] != 4'h0) top = i;
        return top;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational hex nibble to a..g segment decode.
module seg7_dec
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_HEX[nib];
endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan scheduler with blanking and frame-aligned loads.
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIG          = 4,
    parameter int BLANK_TICKS    = 1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       tick,
    input  logic                       load,
    input  logic [4*N_DIG-1:0]         data,
    input  logic [N_DIG-1:0]           dp,
    output logic                       load_ack,
    output logic                       frame_done,
    output logic [$clog2(N_DIG)-1:0]   scancnt,
    output logic [N_DIG-1:0]           dig,
    output logic [7:0]                 seg
);
    localparam int               IW      = $clog2(N_DIG);
    localparam logic [IW-1:0]    LAST    = IW'(N_DIG - 1);
    localparam logic [N_DIG-1:0] DIG_OFF = {N_DIG{DIG_ACTIVE_LOW}};

    scan_state_e          state;
    logic [3:0]           bcnt;
    logic [4*N_DIG-1:0]   act, pend, act_n;
    logic [N_DIG-1:0]     act_dp, pend_dp, act_dp_n;
    logic                 pflag;

    logic                 adv, boundary, take_new, take_pend, lit;
    logic [IW-1:0]        nxt_idx;
    logic [3:0]           nib;
    logic [6:0]           seg7;
    logic [N_DIG-1:0]     dig_n;
    logic [7:0]           seg_n;

    // Everything downstream is computed from the post-edge view (next digit,
    // next active data) so the registered outputs line up with frame_done/load_ack.
    always_comb begin
        adv = 1'b0;
        if (en && tick)
            adv = (state == SHOW && BLANK_TICKS == 0) || (state == BLANK && bcnt == 4'd1);
        boundary  = adv && (scancnt == LAST);
        nxt_idx   = boundary ? '0 : (adv ? scancnt + 1'b1 : scancnt);
        take_new  = boundary && load;
        take_pend = boundary && !load && pflag;
        act_n     = take_new ? data : (take_pend ? pend : act);
        act_dp_n  = take_new ? dp : (take_pend ? pend_dp : act_dp);
        nib       = act_n[{nxt_idx, 2'b00} +: 4];
`ifdef DISP_LZB_EN
        lit       = int'(nxt_idx) <= top_digit(32'(act_n), N_DIG);
`else
        lit       = 1'b1;
`endif
        dig_n     = lit ? ((N_DIG'(1) << nxt_idx) ^ DIG_OFF) : DIG_OFF;
        seg_n     = lit ? {act_dp_n[nxt_idx], seg7} : {1'b0, SEG_OFF};
    end

    seg7_dec u_dec (
        .nib (nib),
        .seg (seg7)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bcnt       <= '0;
            scancnt    <= '0;
            dig        <= DIG_OFF;
            seg        <= '0;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
            act        <= '0;
            act_dp     <= '0;
            pend       <= '0;
            pend_dp    <= '0;
            pflag      <= 1'b0;
        end else begin
            frame_done <= boundary;
            load_ack   <= take_new || take_pend;
            if (take_new || take_pend) begin
                act    <= act_n;
                act_dp <= act_dp_n;
                pflag  <= 1'b0;
            end else if (load) begin
                pend    <= data;
                pend_dp <= dp;
                pflag   <= 1'b1;
            end

            if (!en) begin
                state   <= IDLE;
                scancnt <= '0;
                dig     <= DIG_OFF;
                seg     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= SHOW;
                        scancnt <= '0;
                        dig     <= dig_n;
                        seg     <= seg_n;
                    end
                    SHOW: if (tick) begin
                        if (BLANK_TICKS == 0) begin
                            scancnt <= nxt_idx;
                            dig     <= dig_n;
                            seg     <= seg_n;
                        end else begin
                            state <= BLANK;
                            bcnt  <= 4'(BLANK_TICKS);
                            dig   <= DIG_OFF;
                            seg   <= '0;
                        end
                    end
                    BLANK: if (tick) begin
                        if (adv) begin
                            state   <= SHOW;
                            scancnt <= nxt_idx;
                            dig     <= dig_n;
                            seg     <= seg_n;
                        end else begin
                            bcnt <= bcnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized bench for disp_scan_ctrl; two configurations against a slot-position model.
module tb_disp_scan_ctrl;
    logic        clk = 1'b0, reset = 1'b0, en = 1'b0, tick = 1'b0, load = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  dp = '0;

    logic       ack_a, fd_a, ack_b, fd_b;
    logic [1:0] sc_a, sc_b;
    logic [3:0] dig_a;
    logic [2:0] dig_b;
    logic [7:0] seg_a, seg_b;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.N_DIG(4), .BLANK_TICKS(1), .DIG_ACTIVE_LOW(1'b1)) u_a (
        .clk(clk), .reset(reset), .en(en), .tick(tick), .load(load),
        .data(data[15:0]), .dp(dp[3:0]), .load_ack(ack_a), .frame_done(fd_a),
        .scancnt(sc_a), .dig(dig_a), .seg(seg_a)
    );

    disp_scan_ctrl #(.N_DIG(3), .BLANK_TICKS(0), .DIG_ACTIVE_LOW(1'b0)) u_b (
        .clk(clk), .reset(reset), .en(en), .tick(tick), .load(load),
        .data(data[11:0]), .dp(dp[2:0]), .load_ack(ack_b), .frame_done(fd_b),
        .scancnt(sc_b), .dig(dig_b), .seg(seg_b)
    );

    // Model: position within the frame counted in ticks; digit = pos/slot,
    // lit only in the first tick of each slot.
    int          nd[2] = '{4, 3};
    int          bt[2] = '{1, 0};
    bit          al[2] = '{1'b1, 1'b0};
    bit          run[2];
    int          pos[2];
    logic [31:0] act[2], pend[2];
    logic [7:0]  adp[2], pdp[2];
    bit          pf[2], exp_fd[2], exp_ack[2];

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            run[k] = 0; pos[k] = 0; act[k] = '0; pend[k] = '0;
            adp[k] = '0; pdp[k] = '0; pf[k] = 0; exp_fd[k] = 0; exp_ack[k] = 0;
        end
    endtask

    task automatic model_step();
        if (!reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            int          slot;
            bit          bnd;
            logic [31:0] dmask;
            logic [7:0]  pmask;
            slot  = 1 + bt[k];
            bnd   = 0;
            dmask = (32'd1 << (4 * nd[k])) - 32'd1;
            pmask = 8'((1 << nd[k]) - 1);
            if (!en) begin
                run[k] = 0; pos[k] = 0;
            end else if (!run[k]) begin
                run[k] = 1; pos[k] = 0;
            end else if (tick) begin
                pos[k] = (pos[k] + 1) % (slot * nd[k]);
                bnd    = (pos[k] == 0);
            end
            exp_ack[k] = 0;
            if (bnd && load) begin
                act[k] = data & dmask; adp[k] = dp & pmask; exp_ack[k] = 1; pf[k] = 0;
            end else if (bnd && pf[k]) begin
                act[k] = pend[k]; adp[k] = pdp[k]; exp_ack[k] = 1; pf[k] = 0;
            end else if (load) begin
                pend[k] = data & dmask; pdp[k] = dp & pmask; pf[k] = 1;
            end
            exp_fd[k] = bnd;
        end
    endtask

    task automatic expect_out(input int k, output int sc, output logic [7:0] dg, output logic [7:0] sg);
        int d;
        bit on;
        d  = pos[k] / (1 + bt[k]);
        on = run[k] && (pos[k] % (1 + bt[k]) == 0);
`ifdef DISP_LZB_EN
        begin
            int top;
            top = 0;
            for (int i = 0; i < nd[k]; i++)
                if (act[k][4*i +: 4] != 4'h0) top = i;
            if (d > top) on = 0;
        end
`endif
        sc = run[k] ? d : 0;
        dg = on ? (8'd1 << d) : 8'd0;
        if (al[k]) dg = dg ^ 8'((1 << nd[k]) - 1);
        sg = on ? {adp[k][d], seg_of(act[k][4*d +: 4])} : 8'd0;
    endtask

    task automatic check_all();
        int         sc;
        logic [7:0] dg, sg;
        expect_out(0, sc, dg, sg);
        chk("scan_a", 32'(sc_a), sc);
        chk("dig_a", 32'(dig_a), 32'(dg));
        chk("seg_a", 32'(seg_a), 32'(sg));
        chk("fd_a", 32'(fd_a), 32'(exp_fd[0]));
        chk("ack_a", 32'(ack_a), 32'(exp_ack[0]));
        expect_out(1, sc, dg, sg);
        chk("scan_b", 32'(sc_b), sc);
        chk("dig_b", 32'(dig_b), 32'(dg));
        chk("seg_b", 32'(seg_b), 32'(sg));
        chk("fd_b", 32'(fd_b), 32'(exp_fd[1]));
        chk("ack_b", 32'(ack_b), 32'(exp_ack[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        tick = 1'b0;
        load = 1'b0;
    endtask

    // Ticks every third cycle; returns how many load_acks DUT A produced.
    task automatic run_cycles(input int n, output int acks);
        acks = 0;
        for (int i = 0; i < n; i++) begin
            tick = (i % 3 == 2);
            step();
            acks += int'(ack_a);
        end
    endtask

    task automatic tick_until_pos(input int p, input string tag);
        int i;
        for (i = 0; i < 200 && !(run[0] && pos[0] == p); i++) begin
            tick = 1'b1;
            step();
        end
        if (i == 200) chk(tag, 32'd0, 32'd1);
    endtask

    initial begin
        int acks;
        model_reset();
        repeat (2) step();
        chk("rst_dig_a", 32'(dig_a), 32'h0F);
        chk("rst_seg_a", 32'(seg_a), 32'h00);

        reset = 1'b1; en = 1'b1;
        step();
        load = 1'b1; data = 32'h1234; dp = 8'h00;
        step();
        run_cycles(60, acks);
        chk("ack_once_1234", acks, 1);

        load = 1'b1; data = 32'hAAAA;
        step();
        step();
        load = 1'b1; data = 32'h5555;
        step();
        run_cycles(60, acks);
        chk("ack_once_5555", acks, 1);

        tick_until_pos(7, "reach_wrap");
        tick = 1'b1; load = 1'b1; data = 32'h9876; dp = 8'h05;
        step();
        chk("coinc_ack", 32'(ack_a), 32'd1);
        chk("coinc_fd", 32'(fd_a), 32'd1);
        chk("coinc_seg", 32'(seg_a), 32'h7D | 32'h80);

        tick_until_pos(4, "reach_dig2");
        en = 1'b0;
        step();
        chk("enoff_dig", 32'(dig_a), 32'h0F);
        chk("enoff_sc", 32'(sc_a), 32'd0);
        en = 1'b1;
        step();
        chk("reen_dig", 32'(dig_a), 32'h0E);

        tick_until_pos(3, "reach_blank");
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
        reset = 1'b1;
        step();
        load = 1'b1; data = 32'h0070; dp = 8'h00;
        step();
        run_cycles(60, acks);

        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom % 40) != 0;
            tick = ($urandom % 3) == 0;
            load = ($urandom % 25) == 0;
            data = $urandom >> (4 * ($urandom % 8));
            dp   = 8'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan scheduler for the multiplexed 7-segment display. It consumes the scan-rate tick from the clock divider and sequences the digit-select and segment lines one digit at a time. Between digits it inserts a programmable blanking interval to suppress ghosting. New display values are taken through a load/ack handshake and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- N_DIG, 4, number of digits scanned (2..8)
- BLANK_TICKS, 1, scan ticks of all-off blanking after each digit (0..15; 0 = no blanking)
- DIG_ACTIVE_LOW, 1, 1: selected digit line driven 0; 0: driven 1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  scan enable; low forces display dark
- tick  in  1  one-clk pulse at scan rate (divider carry-out)
- load  in  1  one-clk request to update display contents
- data  in  4*N_DIG  hex nibbles; bits [3:0] = digit 0 (rightmost)
- dp  in  N_DIG  decimal points, bit i = digit i
- load_ack  out  1  one-clk pulse when loaded data becomes active
- frame_done  out  1  one-clk pulse when the last digit's slot completes
- scancnt  out  clog2(N_DIG)  index of current digit
- dig  out  N_DIG  digit select, one-hot active or all inactive
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-high

## Operation
- States: IDLE, SHOW, BLANK.
- IDLE: entered on reset or en=0.
  - dig all inactive, seg=0, scancnt=0.
  - en=1 moves to SHOW with digit 0 on the next clk.
- SHOW: drive dig[scancnt] active, seg = decode(active nibble scancnt) with dp bit.
  - On tick, if BLANK_TICKS>0: go to BLANK, load blank counter with BLANK_TICKS.
  - On tick, if BLANK_TICKS=0: advance the digit and stay in SHOW.
- BLANK: dig all inactive, seg=0. Each tick decrements the counter. When the counter reaches 0, advance the digit and return to SHOW.
- Advance: scancnt wraps N_DIG-1 -> 0. On wrap, pulse frame_done; this is the frame boundary.
- Load handshake:
  - load captures data and dp into the pending registers and sets the pending flag.
  - A load while pending is already set overwrites it (last wins).
  - At a frame boundary with pending set: pending copies to active, the flag clears, load_ack pulses.
  - load in the same cycle as a frame boundary: the incoming values go straight to active, load_ack pulses in that cycle, and the pending flag clears.
- en falling mid-frame: go to IDLE immediately. Pending data is retained and applied at the first frame boundary after re-enable.
- tick while en=0 is ignored.
- Reset mid-operation: all state clears. Active and pending registers go to 0, the pending flag clears, and no load_ack is issued.

## Timing
- All outputs registered.
- dig/seg/scancnt change on the clk after the tick that causes a transition. frame_done and load_ack are asserted in that same clk.
- Reset values: scancnt=0, dig=all inactive, seg=0, load_ack=0, frame_done=0.
- Slot length per digit: (1+BLANK_TICKS) tick periods. Frame = N_DIG slots.
- Load-to-display latency: ≤ one frame plus one clk.

## Configuration
- DISP_LZB_EN defined: leading-zero blanking.
  - Digits above the most significant nonzero active nibble output seg=0, and their dig line stays inactive during their slot.
  - Digit 0 always displays, so all-zero data shows "0".
  - Slot timing is unchanged.
- Undefined: every digit is displayed, including leading zeros.

## Structure
- Shared package disp_pkg:
  - state enum (IDLE/SHOW/BLANK)
  - 7-bit segment constants for hex 0–F (a..g active-high)
  - SEG_OFF constant
- Sub-module seg7_dec: combinational 4-bit nibble -> 7-bit segment decode using the package constants. Instantiated once on the mux output; the output register sits in disp_scan_ctrl.

## Test plan
- Reset, en=1, load data=16'h1234 dp=0, BLANK_TICKS=1 -> after the first frame boundary, load_ack pulses once. Digit 0 shows seg=8'h66 ("4"), digit 3 shows 8'h06 ("1"), with a dark slot between each digit.
- BLANK_TICKS=0, 8 ticks -> scancnt sequence 0,1,2,3,0,1,2,3; frame_done pulses exactly twice, on each 3->0 wrap.
- Two loads mid-frame (16'hAAAA then 16'h5555) -> one load_ack at the boundary; the display shows 5555.
- load coincident with the wrap tick -> load_ack pulses in the same clk, and the new data is active from digit 0 of the new frame.
- en dropped at scancnt=2 -> dig inactive next clk, scancnt=0. Re-enable restarts at digit 0. Reset asserted mid-BLANK -> all outputs at reset values asynchronously.
- DISP_LZB_EN, data=16'h0070 -> digits 3 and 2 stay dark for their slots; digit 1 shows "7"; digit 0 shows "0".
